// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared lane/game encodings and screen geometry for the lane game
// Imported by the game-state stage and the pixel generator so both agree on geometry.
package game_pkg;

  typedef enum logic [1:0] {
    LANE_MID   = 2'b00,
    LANE_LEFT  = 2'b01,
    LANE_RIGHT = 2'b10,
    LANE_BAD   = 2'b11
  } lane_e;

  typedef enum logic {
    GS_PLAY = 1'b0,
    GS_OVER = 1'b1
  } game_state_e;

  localparam int unsigned DEF_STEP       = 4;
  localparam int unsigned DEF_OBST_H     = 50;
  localparam int unsigned DEF_PLAYER_TOP = 280;
  localparam int unsigned DEF_PLAYER_BOT = 380;
  localparam int unsigned DEF_SCREEN_H   = 480;
  localparam int unsigned DEF_LANE_L_X   = 80;
  localparam int unsigned DEF_LANE_M_X   = 300;
  localparam int unsigned DEF_LANE_R_X   = 520;

  // One lane move from the current lane; opposing presses cancel, 11 recovers to middle.
  function automatic lane_e lane_step(lane_e cur, logic go_left, logic go_right);
    lane_e nxt;
    nxt = cur;
    if (cur == LANE_BAD) begin
      nxt = LANE_MID;
    end else if (go_left && !go_right) begin
      case (cur)
        LANE_RIGHT: nxt = LANE_MID;
        LANE_MID:   nxt = LANE_LEFT;
        default:    nxt = cur;
      endcase
    end else if (go_right && !go_left) begin
      case (cur)
        LANE_LEFT: nxt = LANE_MID;
        LANE_MID:  nxt = LANE_RIGHT;
        default:   nxt = cur;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - one-cycle rising-edge pulse from a debounced button level
// History loads the live level even in reset, so a button held through reset gives no edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev & ~rst;

endmodule

// File: rtl/lane_game_ctrl.sv
// rtl/lane_game_ctrl.sv - game-state stage: player lane, scrolling obstacle, score, collision
// All outputs are registers updated on clk_div for the downstream pixel generator.
import game_pkg::*;

module lane_game_ctrl #(
  parameter int unsigned STEP       = DEF_STEP,
  parameter int unsigned OBST_H     = DEF_OBST_H,
  parameter int unsigned PLAYER_TOP = DEF_PLAYER_TOP,
  parameter int unsigned PLAYER_BOT = DEF_PLAYER_BOT,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned LANE_L_X   = DEF_LANE_L_X,
  parameter int unsigned LANE_M_X   = DEF_LANE_M_X,
  parameter int unsigned LANE_R_X   = DEF_LANE_R_X
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [9:0] object_x,
  output logic [9:0] obstacle_y,
  output logic [1:0] lane,
  output logic       game_over,
  output logic [7:0] score
);

  localparam logic [10:0] W_STEP       = 11'(STEP);
  localparam logic [10:0] W_OBST_H     = 11'(OBST_H);
  localparam logic [10:0] W_PLAYER_TOP = 11'(PLAYER_TOP);
  localparam logic [10:0] W_PLAYER_BOT = 11'(PLAYER_BOT);
  localparam logic [10:0] W_SCREEN_H   = 11'(SCREEN_H);
  localparam logic [9:0]  X_LEFT       = 10'(LANE_L_X);
  localparam logic [9:0]  X_MID        = 10'(LANE_M_X);
  localparam logic [9:0]  X_RIGHT      = 10'(LANE_R_X);

  function automatic logic [9:0] lane_x(lane_e l);
    case (l)
      LANE_LEFT:  return X_LEFT;
      LANE_RIGHT: return X_RIGHT;
      default:    return X_MID;
    endcase
  endfunction

  logic        w_left;
  logic        w_right;
  logic        w_start;
  logic        w_play;
  logic        w_restart;
  logic        w_hit;
  logic        w_wrap;
  logic [10:0] w_obst_sum;
  logic [10:0] w_obst_bot;

  game_state_e r_state;
  game_state_e w_state_next;
  lane_e       r_lane;
  lane_e       w_lane_next;
  logic [9:0]  r_object_x;
  logic [9:0]  r_obst_y;
  logic [7:0]  r_score;

  edge_detect u_edge_left (
    .clk     (clk_div),
    .rst     (rst),
    .i_level (btn_left),
    .o_rise  (w_left)
  );

  edge_detect u_edge_right (
    .clk     (clk_div),
    .rst     (rst),
    .i_level (btn_right),
    .o_rise  (w_right)
  );

  edge_detect u_edge_start (
    .clk     (clk_div),
    .rst     (rst),
    .i_level (btn_start),
    .o_rise  (w_start)
  );

  assign w_play    = (r_state == GS_PLAY);
  assign w_restart = (r_state == GS_OVER) && w_start;

  // Collision uses only registered lane/obstacle, so it lags their update by one edge.
  assign w_obst_bot = {1'b0, r_obst_y} + W_OBST_H;
  assign w_hit      = (r_lane == LANE_MID) &&
                      (w_obst_bot > W_PLAYER_TOP) &&
                      ({1'b0, r_obst_y} < W_PLAYER_BOT);

  assign w_obst_sum = {1'b0, r_obst_y} + W_STEP;
  assign w_wrap     = (w_obst_sum >= W_SCREEN_H);

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_state <= GS_PLAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GS_PLAY: if (w_hit)   w_state_next = GS_OVER;
      GS_OVER: if (w_start) w_state_next = GS_PLAY;
      default:              w_state_next = GS_PLAY;
    endcase
  end

  always_comb begin
    game_over = (r_state == GS_OVER);
  end

  always_comb begin
    w_lane_next = r_lane;
    if (w_restart) begin
      w_lane_next = LANE_MID;
    end else if (w_play) begin
      w_lane_next = lane_step(r_lane, w_left, w_right);
    end
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_lane     <= LANE_MID;
      r_object_x <= X_MID;
    end else begin
      r_lane <= w_lane_next;
      if (w_restart) begin
        r_object_x <= X_MID;
      end else if (w_play) begin
        r_object_x <= lane_x(r_lane);
      end
    end
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      r_obst_y <= '0;
      r_score  <= '0;
    end else if (w_restart) begin
      r_obst_y <= '0;
      r_score  <= '0;
    end else if (w_play && frame_tick) begin
      if (w_wrap) begin
        r_obst_y <= '0;
        r_score  <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
      end else begin
        r_obst_y <= w_obst_sum[9:0];
      end
    end
  end

  assign lane       = r_lane;
  assign object_x   = r_object_x;
  assign obstacle_y = r_obst_y;
  assign score      = r_score;

endmodule

// File: tb/tb_lane_game_ctrl.sv
// tb/tb_lane_game_ctrl.sv - scoreboard bench for lane_game_ctrl against a behavioural game model
module tb_lane_game_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic [9:0] object_x;
  logic [9:0] obstacle_y;
  logic [1:0] lane;
  logic       game_over;
  logic [7:0] score;

  int n_checks = 0;
  int n_errors = 0;

  lane_game_ctrl dut (
    .clk_div    (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .object_x   (object_x),
    .obstacle_y (obstacle_y),
    .lane       (lane),
    .game_over  (game_over),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ox;
    int oy;
    int ln;
    int over;
    int sc;
  } exp_t;

  exp_t exp_q[$];

  // Model: player position -1/0/+1, obstacle as a pixel row, overlap test on row spans.
  int m_pos, m_y, m_score, m_ox;
  bit m_over;
  bit p_l, p_r, p_s;

  function automatic int pos_code(int p);
    return (p < 0) ? 1 : (p > 0) ? 2 : 0;
  endfunction

  always @(posedge clk) begin
    bit el, er, es, hit;
    exp_t e;
    el = btn_left && !p_l;
    er = btn_right && !p_r;
    es = btn_start && !p_s;
    if (rst) begin
      m_pos = 0; m_y = 0; m_score = 0; m_ox = 300; m_over = 0;
    end else if (!m_over) begin
      hit = (m_pos == 0) && (m_y < 380) && (m_y + 50 > 280);
      m_ox = 300 + 220 * m_pos;
      if (el && !er && m_pos > -1) m_pos = m_pos - 1;
      else if (er && !el && m_pos < 1) m_pos = m_pos + 1;
      if (frame_tick) begin
        m_y = m_y + 4;
        if (m_y >= 480) begin
          m_y = 0;
          if (m_score < 255) m_score = m_score + 1;
        end
      end
      m_over = hit;
    end else if (es) begin
      m_pos = 0; m_y = 0; m_score = 0; m_ox = 300; m_over = 0;
    end
    p_l = btn_left; p_r = btn_right; p_s = btn_start;
    e.ox = m_ox; e.oy = m_y; e.ln = pos_code(m_pos); e.over = int'(m_over); e.sc = m_score;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (int'(object_x) != e.ox || int'(obstacle_y) != e.oy || int'(lane) != e.ln ||
          int'(game_over) != e.over || int'(score) != e.sc) begin
        n_errors++;
        $display("FAIL scoreboard t=%0t: got x=%0d y=%0d lane=%0d over=%0d score=%0d expected x=%0d y=%0d lane=%0d over=%0d score=%0d",
                 $time, object_x, obstacle_y, lane, game_over, score, e.ox, e.oy, e.ln, e.over, e.sc);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_ticks(int n);
    repeat (n) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic press(bit l, bit r);
    btn_left = l; btn_right = r; step(3);
    btn_left = 1'b0; btn_right = 1'b0; step(2);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    step(2);
    check("reset_x", int'(object_x), 300);
    check("reset_y", int'(obstacle_y), 0);
    check("reset_over", int'(game_over), 0);
    rst = 1'b0; step();

    // stay middle until the obstacle reaches the player
    pulse_ticks(58);
    check("hit_y", int'(obstacle_y), 232);
    check("hit_over", int'(game_over), 1);
    pulse_ticks(5);
    check("over_frozen_y", int'(obstacle_y), 232);

    // left lane, full screen scroll and wrap
    rst = 1'b1; step(2); rst = 1'b0;
    btn_left = 1'b1; step(100); btn_left = 1'b0; step();
    check("left_lane", int'(lane), 1);
    check("left_x", int'(object_x), 80);
    pulse_ticks(119);
    check("pre_wrap_y", int'(obstacle_y), 476);
    pulse_ticks(1);
    check("wrap_y", int'(obstacle_y), 0);
    check("wrap_score", int'(score), 1);
    check("wrap_over", int'(game_over), 0);

    press(1'b0, 1'b1);
    check("right1_x", int'(object_x), 300);
    press(1'b0, 1'b1);
    check("right2_x", int'(object_x), 520);
    press(1'b0, 1'b1);
    check("right3_x", int'(object_x), 520);
    press(1'b1, 1'b1);
    check("both_lane", int'(lane), 2);

    // back to middle, die, then confirm OVER freezes everything
    press(1'b1, 1'b0);
    pulse_ticks(58);
    check("over2", int'(game_over), 1);
    btn_left = 1'b1;
    pulse_ticks(10);
    check("frz_y", int'(obstacle_y), 232);
    check("frz_lane", int'(lane), 0);
    check("frz_score", int'(score), 1);
    btn_start = 1'b1; step();
    check("restart_y", int'(obstacle_y), 0);
    check("restart_x", int'(object_x), 300);
    check("restart_score", int'(score), 0);
    check("restart_over", int'(game_over), 0);
    btn_start = 1'b0; btn_left = 1'b0; step(2);

    // button held across reset must not move the player
    btn_left = 1'b1; rst = 1'b1; step(2); rst = 1'b0; step(5);
    check("held_rst_lane", int'(lane), 0);
    btn_left = 1'b0; step(); btn_left = 1'b1; step(2);
    frame_tick = 1'b1; step(840); frame_tick = 1'b0; step();
    check("score7", int'(score), 7);
    btn_right = 1'b1; rst = 1'b1; step();
    check("midrst_lane", int'(lane), 0);
    check("midrst_score", int'(score), 0);
    check("midrst_x", int'(object_x), 300);
    rst = 1'b0; btn_right = 1'b0; btn_left = 1'b0; step(2);

    // score saturation
    btn_left = 1'b1; step(2);
    frame_tick = 1'b1; step(30600); frame_tick = 1'b0; step();
    check("sat_score", int'(score), 255);
    frame_tick = 1'b1; step(120); frame_tick = 1'b0; step();
    check("sat_hold", int'(score), 255);
    btn_left = 1'b0;
    rst = 1'b1; step(2); rst = 1'b0;

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) btn_left = ~btn_left;
      if ($urandom_range(7) == 0) btn_right = ~btn_right;
      if ($urandom_range(5) == 0) btn_start = ~btn_start;
      frame_tick = ($urandom_range(3) == 0);
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    step(3);
    check("queue_drained", (exp_q.size() <= 1) ? 1 : 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
